// File: rtl/key_move_collector.sv
// key_move_collector: assembles a four-key chess move (file, rank, file, rank)
// from PS/2 make codes. Break/extended prefixes swallow the following byte;
// backspace, escape and enter edit the move; the finished move is held on
// key1..key4 with en high until move_ack.
// Optional feature macro: KEY_STRICT_ORDER_EN (slots 1/3 letters A-H only,
// slots 2/4 digits 1-8 only). Default build accepts any non-control code.
module key_move_collector #(
   parameter int CODE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   input  logic              move_ack,
   output logic [CODE_W-1:0] key1,
   output logic [CODE_W-1:0] key2,
   output logic [CODE_W-1:0] key3,
   output logic [CODE_W-1:0] key4,
   output logic              en,
   output logic [2:0]        count
);

   typedef enum logic [1:0] {COLLECT, SKIP, READY} state_t;

   localparam logic [CODE_W-1:0] C_BRK  = CODE_W'(8'hF0);
   localparam logic [CODE_W-1:0] C_EXT  = CODE_W'(8'hE0);
   localparam logic [CODE_W-1:0] C_BKSP = CODE_W'(8'h66);
   localparam logic [CODE_W-1:0] C_ENT  = CODE_W'(8'h5A);
   localparam logic [CODE_W-1:0] C_ESC  = CODE_W'(8'h76);

   state_t                       state_q, state_d;
   logic [3:0][CODE_W-1:0]       key_q, key_d;
   logic [2:0]                   count_q, count_d;
   logic                         en_q, en_d;
   logic                         legal;
   logic [1:0]                   last_idx;

`ifdef KEY_STRICT_ORDER_EN
   function automatic logic is_letter(input logic [CODE_W-1:0] c);
      case (c)
         CODE_W'(8'h1C), CODE_W'(8'h32), CODE_W'(8'h21), CODE_W'(8'h23),
         CODE_W'(8'h24), CODE_W'(8'h2B), CODE_W'(8'h34), CODE_W'(8'h33): return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_digit(input logic [CODE_W-1:0] c);
      case (c)
         CODE_W'(8'h16), CODE_W'(8'h1E), CODE_W'(8'h26), CODE_W'(8'h25),
         CODE_W'(8'h2E), CODE_W'(8'h36), CODE_W'(8'h3D), CODE_W'(8'h3E): return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
`endif

   // Slot legality: odd slots (index 0/2) take files, even slots take ranks.
   always_comb begin
`ifdef KEY_STRICT_ORDER_EN
      legal = count_q[0] ? is_digit(code) : is_letter(code);
`else
      legal = 1'b1;
`endif
   end

   // Next-state, slot editing and enable decode.
   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      count_d  = count_q;
      last_idx = 2'(count_q - 3'd1);
      case (state_q)
         COLLECT: begin
            if (code_valid) begin
               if (code == C_BRK || code == C_EXT) begin
                  state_d = SKIP;
               end else if (code == C_ESC) begin
                  key_d   = '0;
                  count_d = 3'd0;
               end else if (code == C_BKSP) begin
                  if (count_q != 3'd0) begin
                     key_d[last_idx] = '0;
                     count_d         = count_q - 3'd1;
                  end
               end else if (code == C_ENT) begin
                  if (count_q == 3'd4) state_d = READY;
               end else if (count_q < 3'd4 && legal) begin
                  key_d[count_q[1:0]] = code;
                  count_d             = count_q + 3'd1;
               end
            end
         end
         SKIP: begin
            // The byte after a prefix is consumed regardless of its value.
            if (code_valid) state_d = COLLECT;
         end
         READY: begin
            // Incoming bytes are dropped; ack wins over a coincident byte.
            if (move_ack) begin
               state_d = COLLECT;
               key_d   = '0;
               count_d = 3'd0;
            end
         end
         default: state_d = COLLECT;
      endcase
      en_d = (state_d == READY);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         key_q   <= '0;
         count_q <= 3'd0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         count_q <= count_d;
         en_q    <= en_d;
      end
   end

   assign key1  = key_q[0];
   assign key2  = key_q[1];
   assign key3  = key_q[2];
   assign key4  = key_q[3];
   assign en    = en_q;
   assign count = count_q;

endmodule

// File: doc/key_move_collector.md
# key_move_collector

Collects PS/2 make codes from the keyboard receiver and assembles a four-key chess move: file, rank, file, rank. It filters break and extended sequences, supports backspace, escape and enter editing, and holds the finished move stable on `key1`–`key4` with `en` high. These outputs drive the square decoder directly. The move stays held until the game controller acknowledges it.

## Interface
Parameters:
- `CODE_W`, 8: scan-code width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `code_valid`  in  1  one-cycle strobe from the PS/2 receiver: `code` holds a new byte.
- `code`  in  CODE_W  received scan code.
- `move_ack`  in  1  controller has consumed the move; clears the collector.
- `key1`, `key2`, `key3`, `key4`  out  CODE_W each  slot 1–4 scan codes: file, rank, file, rank.
- `en`  out  1  move complete and held; feeds the decoder enable.
- `count`  out  3  number of filled slots, 0–4.

## Operation
Reset (`rst_n`=0), effective immediately and independent of `clk`:
- `key1`–`key4` = 8'h00, `en` = 0, `count` = 0, state = COLLECT.
- Reset mid-collection or mid-READY discards the partial or held move.

Key codes:
- Letters A–H: 1C 32 21 23 24 2B 34 33.
- Digits 1–8: 16 1E 26 25 2E 36 3D 3E.
- Control keys: F0 break prefix, E0 extended prefix, 66 backspace, 5A enter, 76 escape.

States:
- **COLLECT**. On `code_valid`:
  - F0 or E0: go to SKIP.
  - 76 (escape): clear all slots, `count` = 0.
  - 66 (backspace): if `count` > 0, zero slot `count` and decrement `count`; if `count` = 0, no-op.
  - 5A (enter): if `count` = 4, go to READY; otherwise ignored.
  - Any other code: if `count` < 4 and the code is legal for slot `count`+1, write it and increment `count`; otherwise ignored.
- **SKIP**: the next `code_valid` byte is discarded whatever its value (including F0/E0/5A), then return to COLLECT.
- **READY**:
  - `en` = 1; `key1`–`key4` and `count` = 4 are frozen.
  - All `code_valid` bytes are dropped, including F0 prefixes, so no SKIP state is entered.
  - `move_ack` returns to COLLECT with all slots and `count` zeroed.

`move_ack` outside READY is ignored.

## Timing
- `code_valid` is sampled at the rising edge. A slot write or `count` change is visible one cycle later.
- `en` rises the cycle after the enter byte is sampled, i.e. 1-cycle latency.
- `en` falls, and the keys read 00, the cycle after `move_ack` is sampled in READY.
- `move_ack` and `code_valid` together in READY: the ack wins and the byte is dropped. The collector is not re-armed with that byte.
- `code_valid` held high for N cycles counts as N bytes. The upstream receiver guarantees single-cycle strobes.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `KEY_STRICT_ORDER_EN` defined:
  - Slots 1 and 3 accept only letter codes A–H; slots 2 and 4 accept only digit codes 1–8.
  - Any other code in COLLECT (not a control key) is ignored and `count` is unchanged.
- Undefined: any code other than F0/E0/66/5A/76 fills the next slot. Range checking is left to the decoder, which outputs square 64 for invalid input.

## Test plan
- Reset, then bytes 1C,16,24,3E,5A → `key1`–`key4` = 1C,16,24,3E, `count` = 4; `en` = 1 the cycle after 5A and held; `move_ack` → next cycle `en` = 0, keys 00, `count` = 0.
- Bytes 1C,F0,1C,16 → F0 and the following 1C are discarded; `key1` = 1C, `key2` = 16, `count` = 2.
- Bytes 32,1E,66,26 → after 66: `count` = 1 and `key2` = 00; after 26: `key2` = 26, `count` = 2. Byte 66 at `count` = 0 → no change.
- Bytes 21,26,76 → all slots 00, `count` = 0. Byte 5A with `count` = 3 → `en` stays 0.
- In READY, `code_valid` with 1C on the same cycle as `move_ack` → slots cleared and `count` = 0. `rst_n` pulse low between clock edges → outputs zero immediately.
- With `KEY_STRICT_ORDER_EN`: byte 16 at `count` = 0 → ignored, `count` = 0. Without the macro: the same byte fills `key1` = 16, `count` = 1.
